// File: rtl/fc_tx_credit_gate.sv
// VC0 TX credit gate: classifies TLPs by header, admits them to the TX FIFO only
// when the advertised credit limits cover them, and drops reserved-class TLPs.
module fc_tx_credit_gate #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] ph_credit_limit,
  input  logic [DATA_WIDTH-1:0] pd_credit_limit,
  input  logic [DATA_WIDTH-1:0] nph_credit_limit,
  input  logic [DATA_WIDTH-1:0] npd_credit_limit,
  input  logic [DATA_WIDTH-1:0] ch_credit_limit,
  input  logic [DATA_WIDTH-1:0] cd_credit_limit,
  input  logic                  tx_full,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_wr_en,
  output logic [2:0]            blocked,
  output logic                  err
);
  localparam int W = DATA_WIDTH;
  localparam logic [W-1:0] HALF = W'(1) << (W - 1);

  typedef enum logic [1:0] {IDLE, DATA, DROP} state_t;

  state_t              state_q, state_d;
  logic [5:0]          rem_q, rem_d;
  logic [2:0][W-1:0]   hc_q, hc_d, dc_q, dc_d;
  logic                err_q, err_d;

  logic [1:0]   cls;
  logic [W-1:0] len_w, hl, dl, hc_sel, dc_sel, hdr_diff, dat_diff;
  logic         rsvd, hdr_ok, dat_ok, accept;

  assign cls   = in_data[7:6];
  assign rsvd  = (cls == 2'd3);
  assign len_w = {{(W-6){1'b0}}, in_data[5:0]};

  always_comb begin
    hl = ch_credit_limit;
    dl = cd_credit_limit;
    hc_sel = hc_q[2];
    dc_sel = dc_q[2];
    case (cls)
      2'd0: begin hl = ph_credit_limit;  dl = pd_credit_limit;  hc_sel = hc_q[0]; dc_sel = dc_q[0]; end
      2'd1: begin hl = nph_credit_limit; dl = npd_credit_limit; hc_sel = hc_q[1]; dc_sel = dc_q[1]; end
      default: ;
    endcase
  end

  // Modular compare: the limit is "ahead" if the wrapped distance is at most half the space.
  assign hdr_diff = hl - (hc_sel + W'(1));
  assign dat_diff = dl - (dc_sel + len_w);
  assign hdr_ok   = (hdr_diff <= HALF);
  assign dat_ok   = (dat_diff <= HALF);

  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      IDLE:    in_ready = rsvd ? in_valid : (in_valid & hdr_ok & dat_ok & ~tx_full);
      DATA:    in_ready = ~tx_full;
      default: in_ready = 1'b1;
    endcase
  end

  assign accept    = in_valid & in_ready;
  assign out_data  = in_data;
  assign out_wr_en = accept & (state_q != DROP) & ~((state_q == IDLE) & rsvd);
  assign err       = err_q;

  always_comb begin
    for (int c = 0; c < 3; c++)
      blocked[c] = (state_q == IDLE) & in_valid & (cls == 2'(c)) & ~(hdr_ok & dat_ok);
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hc_d    = hc_q;
    dc_d    = dc_q;
    err_d   = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        rem_d = in_data[5:0];
        if (rsvd) begin
          err_d = 1'b1;
          if (in_data[5:0] != 6'd0) state_d = DROP;
        end else begin
          for (int c = 0; c < 3; c++)
            if (cls == 2'(c)) begin
              hc_d[c] = hc_q[c] + W'(1);
              dc_d[c] = dc_q[c] + len_w;
            end
          if (in_data[5:0] != 6'd0) state_d = DATA;
        end
      end
      default: if (accept) begin
        rem_d = rem_q - 6'd1;
        if (rem_q == 6'd1) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      hc_q    <= '0;
      dc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hc_q    <= hc_d;
      dc_q    <= dc_d;
      err_q   <= err_d;
    end
  end
endmodule
